// File: rtl/dl_lshift_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dl_lshift_iter_pkg
//  Description : Shared definitions for the design_lib shifter family: shift
//                kind codes and the shift-amount width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dl_lshift_iter_pkg;

    // Shift-kind codes used across the shifter family.
    typedef enum logic [1:0] {
        LOGICAL_L = 2'd0,
        LOGICAL_R = 2'd1,
        ARITH_R   = 2'd2
    } shift_kind_e;

    // Width of a shift amount able to address every bit of an operand.
    function automatic int dl_shift_width(input int num_bits);
        return $clog2(num_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_lshift_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dl_lshift_iter_if
//  Description : Operand/result valid-ready bus of the iterative left shifter.
//                master = producer/consumer side, slave = shifter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dl_lshift_iter_if
    import dl_lshift_iter_pkg::*;
#(
    parameter int NUM_BITS = 32
);
    localparam int NUM_SHIFT_BITS = dl_shift_width(NUM_BITS);

    logic                      in_val;
    logic                      in_rdy;
    logic [NUM_BITS-1:0]       a;
    logic [NUM_SHIFT_BITS-1:0] shift;
    logic                      out_val;
    logic                      out_rdy;
    logic [NUM_BITS-1:0]       out;

    modport master (
        output in_val, a, shift, out_rdy,
        input  in_rdy, out_val, out
    );

    modport slave (
        input  in_val, a, shift, out_rdy,
        output in_rdy, out_val, out
    );
endinterface
`default_nettype wire

// File: rtl/dl_lshift_step.sv
`default_nettype none
// ============================================================================
//  Module      : dl_lshift_step
//  Description : One stage of the iterative left shifter: shifts the data by
//                2**k when enabled, passes it through otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module dl_lshift_step #(
    parameter int NUM_BITS       = 32,
    parameter int NUM_SHIFT_BITS = 5
) (
    input  wire logic [NUM_BITS-1:0]       i_data,
    input  wire logic [NUM_SHIFT_BITS-1:0] i_k,
    input  wire logic                      i_en,
    output logic      [NUM_BITS-1:0]       o_data
);
    // One extra bit keeps 2**k representable for every legal k.
    logic [NUM_SHIFT_BITS:0] w_dist;

    // Select between the shifted and the untouched operand.
    always_comb begin
        w_dist = (NUM_SHIFT_BITS + 1)'(1) << i_k;
        o_data = i_en ? (i_data << w_dist) : i_data;
    end
endmodule
`default_nettype wire

// File: rtl/dl_lshift_iter.sv
`default_nettype none
// ============================================================================
//  Module      : dl_lshift_iter
//  Description : Iterative logical left shifter. Resolves one shift-amount bit
//                per cycle, so latency is NUM_SHIFT_BITS cycles for any shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module dl_lshift_iter
    import dl_lshift_iter_pkg::*;
#(
    parameter int NUM_BITS = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dl_lshift_iter_if.slave bus
);
    localparam int NUM_SHIFT_BITS = dl_shift_width(NUM_BITS);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [NUM_SHIFT_BITS-1:0] c_K_ONE  = NUM_SHIFT_BITS'(1);
    localparam logic [NUM_SHIFT_BITS-1:0] c_K_LAST = NUM_SHIFT_BITS'(NUM_SHIFT_BITS - 1);

    logic [1:0]                r_state;
    logic [NUM_BITS-1:0]       r_data;
    logic [NUM_SHIFT_BITS-1:0] r_amt;
    logic [NUM_SHIFT_BITS-1:0] r_k;
    logic [NUM_BITS-1:0]       r_out;
    logic                      r_out_val;
    logic                      r_in_rdy;

    logic                      w_en;
    logic [NUM_BITS-1:0]       w_step;

    // Pick amt[k] with a mask so the index never exceeds the vector width.
    always_comb begin
        w_en = |(r_amt & (c_K_ONE << r_k));
    end

    dl_lshift_step #(
        .NUM_BITS       (NUM_BITS),
        .NUM_SHIFT_BITS (NUM_SHIFT_BITS)
    ) u_step (
        .i_data (r_data),
        .i_k    (r_k),
        .i_en   (w_en),
        .o_data (w_step)
    );

    // Control FSM, step counter, working data and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_data    <= '0;
            r_amt     <= '0;
            r_k       <= '0;
            r_out     <= '0;
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_val) begin
                        r_data   <= bus.a;
                        r_amt    <= bus.shift;
                        r_k      <= '0;
                        r_in_rdy <= 1'b0;
                        r_state  <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_data <= w_step;
                    if (r_k == c_K_LAST) begin
                        // Counter parks on the last step; it is cleared on the next accept.
                        r_out     <= w_step;
                        r_out_val <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_k <= r_k + c_K_ONE;
                    end
                end
                c_DONE: begin
                    // Result is held until taken; no accept on the release edge.
                    if (bus.out_rdy) begin
                        r_out_val <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_out_val <= 1'b0;
                    r_in_rdy  <= 1'b1;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy  = r_in_rdy;
    assign bus.out_val = r_out_val;
    assign bus.out     = r_out;
endmodule
`default_nettype wire

// File: tb/tb_dl_lshift_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dl_lshift_iter
//  Description : Self-checking bench for dl_lshift_iter (NUM_BITS = 32) with a
//                queue scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_lshift_iter;
    localparam int NUM_BITS = 32;
    localparam int LAT      = 5;

    logic clk;
    logic rst;

    dl_lshift_iter_if #(.NUM_BITS(NUM_BITS)) bus ();

    dl_lshift_iter #(.NUM_BITS(NUM_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] sb[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int accept_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Absolute time bound so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: run time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Wait for in_rdy, present one operand, push its expected result.
    task automatic send(input logic [31:0] av, input logic [4:0] sh);
        int t = 0;
        while (!bus.in_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_rdy) begin
            n_fail++;
            $display("FAIL send_timeout: in_rdy actual=%0b required=1", bus.in_rdy);
        end
        bus.in_val = 1'b1;
        bus.a      = av;
        bus.shift  = sh;
        sb.push_back(av << sh);
        accept_cyc = cyc + 1;
        @(negedge clk);
        bus.in_val = 1'b0;
        bus.a      = $urandom;
        bus.shift  = 5'($urandom);
    endtask

    // Count edges after the accepting edge until out_val rises.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_val && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Take the result with a single out_rdy pulse.
    task automatic consume();
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.out_val !== 1'b0 || bus.out !== 32'h0 || bus.in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: out_val/out/in_rdy actual=%b/%h/%b required=0/00000000/1",
                     bus.out_val, bus.out, bus.in_rdy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] av[3] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [4:0]  sv[3] = '{5'd31, 5'd4, 5'd0};
        logic [31:0] exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(av[i], sv[i]);
            wait_out(lat);
            exp = sb.pop_front();
            n_cmp++;
            if (bus.out !== exp) begin
                n_fail++;
                $display("FAIL basic_out[%0d]: actual=%h required=%h", i, bus.out, exp);
            end
            n_cmp++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: actual=%0d required=%0d", i, lat, LAT);
            end
            consume();
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        int lat;
        send(32'h1234_5678, 5'd12);
        wait_out(lat);
        exp = sb.pop_front();
        n_cmp++;
        if (bus.out !== exp) begin
            n_fail++;
            $display("FAIL hold_out: actual=%h required=%h", bus.out, exp);
        end
        for (int i = 0; i < 3; i++) begin
            bus.in_val = 1'b1;
            bus.a      = $urandom;
            bus.shift  = 5'($urandom);
            @(negedge clk);
            n_cmp++;
            if (bus.out !== exp || bus.out_val !== 1'b1 || bus.in_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: out/out_val/in_rdy actual=%h/%b/%b required=%h/1/0",
                         i, bus.out, bus.out_val, bus.in_rdy, exp);
            end
        end
        bus.in_val = 1'b0;
        consume();
        @(negedge clk);
        n_cmp++;
        if (bus.in_rdy !== 1'b1 || bus.out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: in_rdy/out_val actual=%b/%b required=1/0",
                     bus.in_rdy, bus.out_val);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int lat;
        int prev = 0;
        bus.out_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send(32'h1, 5'(i));
            if (i > 1) begin
                n_cmp++;
                if (accept_cyc - prev !== 7) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: actual=%0d required=7", i, accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            wait_out(lat);
            exp = sb.pop_front();
            n_cmp++;
            if (bus.out !== exp) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: actual=%h required=%h", i, bus.out, exp);
            end
        end
        @(negedge clk);
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] exp;
        int lat;
        send(32'hFFFF_FFFF, 5'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        n_cmp++;
        if (bus.out_val !== 1'b0 || bus.out !== 32'h0 || bus.in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: out_val/out/in_rdy actual=%b/%h/%b required=0/00000000/1",
                     bus.out_val, bus.out, bus.in_rdy);
        end
        send(32'hF, 5'd8);
        wait_out(lat);
        exp = sb.pop_front();
        n_cmp++;
        if (bus.out !== exp || lat !== LAT) begin
            n_fail++;
            $display("FAIL rst_recover: out/lat actual=%h/%0d required=%h/%0d", bus.out, lat, exp, LAT);
        end
        consume();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int lat;
        int stall;
        for (int i = 0; i < 2000; i++) begin
            send($urandom, 5'($urandom_range(0, 31)));
            wait_out(lat);
            exp = sb.pop_front();
            n_cmp++;
            if (bus.out !== exp || lat !== LAT) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: out/lat actual=%h/%0d required=%h/%0d",
                         i, bus.out, lat, exp, LAT);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            n_cmp++;
            if (bus.out !== exp || bus.out_val !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: out/out_val actual=%h/%b required=%h/1",
                         i, bus.out, bus.out_val, exp);
            end
            consume();
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_val  = 1'b0;
        bus.a       = '0;
        bus.shift   = '0;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
